// File: rtl/reg_write_arbiter_if.sv
// Bundle between the requesting units and the shared register-bank write port.
// Requester-side signals (i_*) and bank-side signals (o_*) keep the arbiter's port naming.
interface reg_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDR_W  = 3
);
    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ-1:0]        i_lock;
    logic [NUM_REQ*ADDR_W-1:0] i_addr;
    logic [NUM_REQ*WIDTH-1:0]  i_data;
    logic [NUM_REQ-1:0]        o_gnt;
    logic                      o_we;
    logic [ADDR_W-1:0]         o_waddr;
    logic [WIDTH-1:0]          o_wdata;
    logic [15:0]               o_xfer_cnt;

    // Requesters plus bank observer.
    modport master (
        output i_req, i_lock, i_addr, i_data,
        input  o_gnt, o_we, o_waddr, o_wdata, o_xfer_cnt
    );

    // The arbiter itself.
    modport slave (
        input  i_req, i_lock, i_addr, i_data,
        output o_gnt, o_we, o_waddr, o_wdata, o_xfer_cnt
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among NUM_REQ requesters.
// Grant is combinational; the winning write reaches the bank one cycle later.
module reg_write_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDR_W  = 3
) (
    input  logic                 i_clk,
    input  logic                 i_arstn,
    input  logic                 i_srstn,
    reg_write_arbiter_if.slave   bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   win;
    logic               found;
    logic               xfer;
    int unsigned        cand;

    // Rotating priority search starting at ptr_q; both resets mask the grant.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && bus.i_req[cand]) begin
                found     = 1'b1;
                win       = PTR_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
        if (!i_arstn || !i_srstn) begin
            gnt   = '0;
            found = 1'b0;
        end
    end

    assign xfer = |(gnt & bus.i_req);

    always_comb begin
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            we_d    = 1'b1;
            waddr_d = bus.i_addr[win*ADDR_W +: ADDR_W];
            wdata_d = bus.i_data[win*WIDTH +: WIDTH];
            cnt_d   = cnt_q + 16'd1;
            // A locked winner keeps top priority; otherwise rotate past it.
            if (bus.i_lock[win]) begin
                ptr_d = win;
            end else if (win == LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = win + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else if (!i_srstn) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_gnt      = gnt;
    assign bus.o_we       = we_q;
    assign bus.o_waddr    = waddr_q;
    assign bus.o_wdata    = wdata_q;
    assign bus.o_xfer_cnt = cnt_q;

    a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_arstn)
        $onehot0(gnt));
    a_gnt_subset: assert property (@(posedge i_clk) disable iff (!i_arstn)
        (gnt & ~bus.i_req) == '0);
endmodule
